ps2_key_event_fifo: RTL and testbench

Parametrised PS/2 set-2 scan-code parser that turns the received byte stream into buffered key events. It handles extended (E0) prefixes, left/right modifiers, caps lock, and typematic-repeat suppression. It sits between the PS/2 receiver (one byte + one-cycle valid) and consumers such as the seven-segment display or a CPU-side keyboard register. Events are read out through a valid/ready FIFO port.

---
 rtl/ps2_key_event_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_key_event_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_fifo.sv
// PS/2 set-2 scan-code parser feeding a valid/ready key-event FIFO.
// Tracks shift/ctrl/caps state, suppresses typematic repeats and counts releases.
module ps2_key_event_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter bit REPEAT_EN  = 1'b0,
  parameter bit BREAK_EVT  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    ps2_data,
  input  logic                          ps2_valid,
  input  logic                          ev_ready,
  input  logic                          ovf_clr,
  output logic                          ev_valid,
  output logic [19:0]                   ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              key_cnt,
  output logic                          shift_flag,
  output logic                          ctrl_flag,
  output logic                          caps_flag,
  output logic                          ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t             state_q, state_d;
  logic               lshift_q, lshift_d, rshift_q, rshift_d;
  logic               lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic               caps_q, caps_d;
  logic               held_valid_q, held_valid_d, held_ext_q, held_ext_d;
  logic [7:0]         held_code_q, held_code_d;
  logic [CNT_W-1:0]   key_cnt_q, key_cnt_d;
  logic [19:0]        mem_q [FIFO_DEPTH];
  logic [19:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [19:0]        ev_data_q, ev_data_d;
  logic               ovf_q, ovf_d;

  logic               key_valid, key_brk, key_ext;
  logic               is_lshift, is_rshift, is_lctrl, is_rctrl, is_caps, is_mod, is_plain, is_rep;
  logic               push, pop, full, accept, drop;
  logic [19:0]        push_data;

  // Lowercase/digit/control ASCII for a non-extended code; letters shift up when upper is set.
  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
    logic [7:0] c;
    c = 8'h00;
    case (code)
      8'h16: c = 8'h31;  8'h1E: c = 8'h32;  8'h26: c = 8'h33;  8'h25: c = 8'h34;
      8'h2E: c = 8'h35;  8'h36: c = 8'h36;  8'h3D: c = 8'h37;  8'h3E: c = 8'h38;
      8'h46: c = 8'h39;  8'h45: c = 8'h30;
      8'h1C: c = 8'h61;  8'h32: c = 8'h62;  8'h21: c = 8'h63;  8'h23: c = 8'h64;
      8'h24: c = 8'h65;  8'h2B: c = 8'h66;  8'h34: c = 8'h67;  8'h33: c = 8'h68;
      8'h43: c = 8'h69;  8'h3B: c = 8'h6A;  8'h42: c = 8'h6B;  8'h4B: c = 8'h6C;
      8'h3A: c = 8'h6D;  8'h31: c = 8'h6E;  8'h44: c = 8'h6F;  8'h4D: c = 8'h70;
      8'h15: c = 8'h71;  8'h2D: c = 8'h72;  8'h1B: c = 8'h73;  8'h2C: c = 8'h74;
      8'h3C: c = 8'h75;  8'h2A: c = 8'h76;  8'h1D: c = 8'h77;  8'h22: c = 8'h78;
      8'h35: c = 8'h79;  8'h1A: c = 8'h7A;
      8'h29: c = 8'h20;  8'h5A: c = 8'h0D;  8'h66: c = 8'h08;
      default: c = 8'h00;
    endcase
    if (upper && c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
    return c;
  endfunction

  // Parser FSM: turns the byte stream into make/break key strokes with an extended tag.
  always_comb begin
    state_d   = state_q;
    key_valid = 1'b0;
    key_brk   = 1'b0;
    key_ext   = 1'b0;
    if (ps2_valid) begin
      case (state_q)
        S_IDLE: begin
          if (ps2_data == 8'hE0)      state_d = S_EXT;
          else if (ps2_data == 8'hF0) state_d = S_BRK;
          else if (ps2_data == 8'hE1 || ps2_data == 8'hAA ||
                   ps2_data == 8'hFA || ps2_data == 8'hEE) state_d = S_IDLE;
          else key_valid = 1'b1;
        end
        S_EXT: begin
          if (ps2_data == 8'hF0) state_d = S_EXT_BRK;
          else begin
            key_valid = 1'b1;
            key_ext   = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_BRK: begin
          key_valid = 1'b1;
          key_brk   = 1'b1;
          state_d   = S_IDLE;
        end
        default: begin
          key_valid = 1'b1;
          key_brk   = 1'b1;
          key_ext   = 1'b1;
          state_d   = S_IDLE;
        end
      endcase
    end
  end

  // Key classification, modifier/caps/held tracking, release counting and push request.
  always_comb begin
    is_lshift = !key_ext && ps2_data == 8'h12;
    is_rshift = !key_ext && ps2_data == 8'h59;
    is_lctrl  = !key_ext && ps2_data == 8'h14;
    is_rctrl  =  key_ext && ps2_data == 8'h14;
    is_caps   = !key_ext && ps2_data == 8'h58;
    is_mod    = is_lshift || is_rshift || is_lctrl || is_rctrl;
    is_plain  = !is_mod && !is_caps;
    is_rep    = held_valid_q && held_ext_q == key_ext && held_code_q == ps2_data;
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    lctrl_d      = lctrl_q;
    rctrl_d      = rctrl_q;
    caps_d       = caps_q;
    held_valid_d = held_valid_q;
    held_ext_d   = held_ext_q;
    held_code_d  = held_code_q;
    key_cnt_d    = key_cnt_q;
    push         = 1'b0;
    push_data    = {key_brk, key_ext, lshift_q | rshift_q, lctrl_q | rctrl_q,
                    key_ext ? 8'h00 : ascii_of(ps2_data, (lshift_q | rshift_q) ^ caps_q),
                    ps2_data};
    if (key_valid) begin
      if (is_lshift) lshift_d = !key_brk;
      if (is_rshift) rshift_d = !key_brk;
      if (is_lctrl)  lctrl_d  = !key_brk;
      if (is_rctrl)  rctrl_d  = !key_brk;
      if (!key_brk) begin
        if (!is_mod) begin
          held_valid_d = 1'b1;
          held_ext_d   = key_ext;
          held_code_d  = ps2_data;
        end
        if (is_caps && !is_rep) caps_d = !caps_q;
        if (is_plain && (REPEAT_EN || !is_rep)) push = 1'b1;
      end else begin
        if (!is_mod && is_rep) held_valid_d = 1'b0;
        if (is_plain) begin
          key_cnt_d = key_cnt_q + CNT_W'(1);
          if (BREAK_EVT) push = 1'b1;
        end
      end
    end
  end

  // FIFO bookkeeping; the registered head is the entry that will sit at rd_ptr next cycle.
  always_comb begin
    pop    = (count_q != '0) && ev_ready;
    full   = count_q == CW'(FIFO_DEPTH);
    accept = push && (!full || pop);
    drop   = push && full && !pop;
    mem_d  = mem_q;
    if (accept) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (!accept && pop) count_d = count_q - CW'(1);
    ev_data_d = (count_d == '0) ? 20'h0 : mem_d[rd_ptr_d];
    ovf_d     = (ovf_q && !ovf_clr) || drop;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      lctrl_q      <= 1'b0;
      rctrl_q      <= 1'b0;
      caps_q       <= 1'b0;
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
      key_cnt_q    <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ev_data_q    <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      lctrl_q      <= lctrl_d;
      rctrl_q      <= rctrl_d;
      caps_q       <= caps_d;
      held_valid_q <= held_valid_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
      key_cnt_q    <= key_cnt_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ev_data_q    <= ev_data_d;
      ovf_q        <= ovf_d;
    end
  end

  assign ev_valid   = count_q != '0;
  assign ev_data    = ev_data_q;
  assign fifo_count = count_q;
  assign key_cnt    = key_cnt_q;
  assign shift_flag = lshift_q | rshift_q;
  assign ctrl_flag  = lctrl_q | rctrl_q;
  assign caps_flag  = caps_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Directed bench for ps2_key_event_fifo: two instances share stimulus,
// A = depth 4 / 2-bit counter / makes only, B = defaults with break events.
module tb_ps2_key_event_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ps2_data;
  logic        ps2_valid;
  logic        ev_ready;
  logic        ovf_clr;

  logic        a_ev_valid, a_shift, a_ctrl, a_caps, a_ovf;
  logic [19:0] a_ev_data;
  logic [2:0]  a_fifo_count;
  logic [1:0]  a_key_cnt;
  logic        b_ev_valid, b_shift, b_ctrl, b_caps, b_ovf;
  logic [19:0] b_ev_data;
  logic [3:0]  b_fifo_count;
  logic [7:0]  b_key_cnt;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ps2_key_event_fifo #(.FIFO_DEPTH(4), .CNT_W(2), .REPEAT_EN(1'b0), .BREAK_EVT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .ev_ready(ev_ready), .ovf_clr(ovf_clr), .ev_valid(a_ev_valid), .ev_data(a_ev_data),
    .fifo_count(a_fifo_count), .key_cnt(a_key_cnt), .shift_flag(a_shift),
    .ctrl_flag(a_ctrl), .caps_flag(a_caps), .ovf(a_ovf));

  ps2_key_event_fifo #(.FIFO_DEPTH(8), .CNT_W(8), .REPEAT_EN(1'b0), .BREAK_EVT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .ev_ready(ev_ready), .ovf_clr(ovf_clr), .ev_valid(b_ev_valid), .ev_data(b_ev_data),
    .fifo_count(b_fifo_count), .key_cnt(b_key_cnt), .shift_flag(b_shift),
    .ctrl_flag(b_ctrl), .caps_flag(b_caps), .ovf(b_ovf));

  // Called at a negedge; presents one byte across the next posedge, returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    ps2_data  = b;
    ps2_valid = 1'b1;
    @(negedge clk);
    ps2_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    ps2_valid = 1'b0;
    ev_ready  = 1'b0;
    ovf_clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_ev_valid !== 1'b0) $display("[TB] FAIL rst_ev_valid: got %b exp 0", a_ev_valid); else passes++;
    checks++; if (a_ev_data !== 20'h0) $display("[TB] FAIL rst_ev_data: got %h exp 00000", a_ev_data); else passes++;
    checks++; if ({a_fifo_count, a_key_cnt, a_shift, a_ctrl, a_caps, a_ovf} !== 9'h0)
      $display("[TB] FAIL rst_misc: got %h exp 000", {a_fifo_count, a_key_cnt, a_shift, a_ctrl, a_caps, a_ovf}); else passes++;
    checks++; if ({b_ev_valid, b_ev_data, b_fifo_count, b_key_cnt} !== 33'h0)
      $display("[TB] FAIL rst_b: got %h exp 0", {b_ev_valid, b_ev_data, b_fifo_count, b_key_cnt}); else passes++;
  endtask

  task automatic test_make_break();
    do_reset();
    send_byte(8'h1C);
    checks++; if (a_ev_valid !== 1'b1) $display("[TB] FAIL mk_latency_valid: got %b exp 1", a_ev_valid); else passes++;
    checks++; if (a_ev_data !== 20'h0611C) $display("[TB] FAIL mk_latency_data: got %h exp 0611c", a_ev_data); else passes++;
    send_byte(8'hF0);
    send_byte(8'h1C);
    checks++; if (a_ev_data !== 20'h0611C) $display("[TB] FAIL mk_data: got %h exp 0611c", a_ev_data); else passes++;
    checks++; if (a_key_cnt !== 2'd1) $display("[TB] FAIL mk_key_cnt: got %0d exp 1", a_key_cnt); else passes++;
    checks++; if (a_fifo_count !== 3'd1) $display("[TB] FAIL mk_count_a: got %0d exp 1", a_fifo_count); else passes++;
    checks++; if (b_fifo_count !== 4'd2) $display("[TB] FAIL mk_count_b: got %0d exp 2", b_fifo_count); else passes++;
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    checks++; if ({a_ev_valid, a_ev_data} !== 21'h0) $display("[TB] FAIL mk_empty_a: got %h exp 0", {a_ev_valid, a_ev_data}); else passes++;
    checks++; if (b_ev_data !== 20'h8611C) $display("[TB] FAIL brk_evt_b: got %h exp 8611c", b_ev_data); else passes++;
    checks++; if (b_key_cnt !== 8'd1) $display("[TB] FAIL brk_cnt_b: got %0d exp 1", b_key_cnt); else passes++;
  endtask

  task automatic test_repeat_caps();
    do_reset();
    send_byte(8'h12);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    checks++; if (a_fifo_count !== 3'd1) $display("[TB] FAIL rep_drop_count: got %0d exp 1", a_fifo_count); else passes++;
    checks++; if (a_ev_data !== 20'h2411C) $display("[TB] FAIL rep_upper: got %h exp 2411c", a_ev_data); else passes++;
    checks++; if (a_shift !== 1'b1) $display("[TB] FAIL rep_shift: got %b exp 1", a_shift); else passes++;
    send_byte(8'h58);
    checks++; if (a_caps !== 1'b1) $display("[TB] FAIL caps_flag: got %b exp 1", a_caps); else passes++;
    checks++; if (a_fifo_count !== 3'd1) $display("[TB] FAIL caps_no_evt: got %0d exp 1", a_fifo_count); else passes++;
    send_byte(8'h1C);
    checks++; if (a_fifo_count !== 3'd2) $display("[TB] FAIL caps_then_a_count: got %0d exp 2", a_fifo_count); else passes++;
    checks++; if (a_ev_data !== 20'h2411C) $display("[TB] FAIL head_stable: got %h exp 2411c", a_ev_data); else passes++;
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    checks++; if (a_ev_data !== 20'h2611C) $display("[TB] FAIL caps_shift_lower: got %h exp 2611c", a_ev_data); else passes++;
  endtask

  task automatic test_ext_ctrl();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h14);
    checks++; if (b_ctrl !== 1'b1) $display("[TB] FAIL rctrl_set: got %b exp 1", b_ctrl); else passes++;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h14);
    checks++; if (b_ctrl !== 1'b0) $display("[TB] FAIL rctrl_clr: got %b exp 0", b_ctrl); else passes++;
    checks++; if ({b_fifo_count, b_key_cnt} !== 12'h0) $display("[TB] FAIL mod_no_evt: got %h exp 000", {b_fifo_count, b_key_cnt}); else passes++;
    send_byte(8'hE0);
    send_byte(8'h75);
    checks++; if (b_fifo_count !== 4'd1) $display("[TB] FAIL ext_count: got %0d exp 1", b_fifo_count); else passes++;
    checks++; if (b_ev_data !== 20'h40075) $display("[TB] FAIL ext_data: got %h exp 40075", b_ev_data); else passes++;
    send_byte(8'h14);
    send_byte(8'h1C);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    checks++; if (b_ev_data !== 20'h1611C) $display("[TB] FAIL ctrl_field: got %h exp 1611c", b_ev_data); else passes++;
  endtask

  task automatic test_fifo_overflow();
    logic [7:0]  makes [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    logic [19:0] drain [4] = '{20'h06232, 20'h06321, 20'h06423, 20'h06734};
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(makes[i]);
    checks++; if (a_fifo_count !== 3'd4) $display("[TB] FAIL full_count: got %0d exp 4", a_fifo_count); else passes++;
    checks++; if (a_ovf !== 1'b1) $display("[TB] FAIL ovf_set: got %b exp 1", a_ovf); else passes++;
    ps2_data  = 8'h34;
    ps2_valid = 1'b1;
    ev_ready  = 1'b1;
    @(negedge clk);
    ps2_valid = 1'b0;
    ev_ready  = 1'b0;
    checks++; if (a_fifo_count !== 3'd4) $display("[TB] FAIL full_push_pop_count: got %0d exp 4", a_fifo_count); else passes++;
    ovf_clr = 1'b1;
    send_byte(8'h33);
    ovf_clr = 1'b0;
    checks++; if (a_ovf !== 1'b1) $display("[TB] FAIL ovf_clr_vs_drop: got %b exp 1", a_ovf); else passes++;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (a_ovf !== 1'b0) $display("[TB] FAIL ovf_clr: got %b exp 0", a_ovf); else passes++;
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_ev_data !== drain[i]) $display("[TB] FAIL drain_%0d: got %h exp %h", i, a_ev_data, drain[i]); else passes++;
      @(negedge clk);
    end
    ev_ready = 1'b0;
    checks++; if ({a_ev_valid, a_ev_data, a_fifo_count} !== 24'h0)
      $display("[TB] FAIL drained_empty: got %h exp 0", {a_ev_valid, a_ev_data, a_fifo_count}); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h1C);
    send_byte(8'h12);
    send_byte(8'hE0);
    send_byte(8'hF0);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({a_ev_valid, a_ev_data, a_fifo_count, a_key_cnt, a_shift, a_ctrl, a_caps, a_ovf} !== 30'h0)
      $display("[TB] FAIL mid_rst_outputs: got %h exp 0", {a_ev_valid, a_ev_data, a_fifo_count, a_key_cnt, a_shift, a_ctrl, a_caps, a_ovf}); else passes++;
    rst = 1'b1;
    send_byte(8'h1C);
    checks++; if (a_ev_data !== 20'h0611C) $display("[TB] FAIL mid_rst_reparse: got %h exp 0611c", a_ev_data); else passes++;
    checks++; if (a_key_cnt !== 2'd0) $display("[TB] FAIL mid_rst_cnt: got %0d exp 0", a_key_cnt); else passes++;
  endtask

  task automatic test_cnt_wrap();
    logic [7:0] keys [5] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_byte(keys[i]);
      send_byte(8'hF0);
      send_byte(keys[i]);
      checks++; if (a_key_cnt !== exp_cnt[i]) $display("[TB] FAIL cnt_wrap_%0d: got %0d exp %0d", i, a_key_cnt, exp_cnt[i]); else passes++;
      if (i == 1) begin
        send_byte(8'h12);
        send_byte(8'hF0);
        send_byte(8'h12);
        checks++; if (a_key_cnt !== 2'd2) $display("[TB] FAIL cnt_mod_brk: got %0d exp 2", a_key_cnt); else passes++;
      end
    end
    ev_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    ps2_data  = 8'h00;
    ps2_valid = 1'b0;
    ev_ready  = 1'b0;
    ovf_clr   = 1'b0;
    @(negedge clk);
    test_reset();
    test_make_break();
    test_repeat_caps();
    test_ext_ctrl();
    test_fifo_overflow();
    test_reset_mid();
    test_cnt_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
